dd_hs_tx: RTL

Source-side transmitter for a two-phase (toggle) request/acknowledge clock-domain-crossing handshake. It accepts words on a valid/ready interface in its own clock domain and presents each word on a held-stable bus. It launches each word by toggling a request level, then waits for the destination's acknowledge toggle, which it resynchronizes internally. It sits at the source end of every multi-bit CDC path. Its counterpart receiver synchronizes `req_o`, samples `data_o` and returns `ack_i`.

---
 rtl/dd_cdc_pkg.sv | 12 +
 rtl/dd_sync.sv | 25 ++
 rtl/dd_hs_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/dd_cdc_pkg.sv
// Shared types and constants for the toggle-handshake CDC transmitter/receiver pair.
package dd_cdc_pkg;

    localparam int XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } hs_tx_state_t;

endpackage

// File: rtl/dd_sync.sv
// Multi-flop level synchronizer; output is the last stage of a STAGES-deep shift chain.
module dd_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dd_hs_tx.sv
// Source end of a two-phase req/ack CDC handshake: holds a word on data_o, toggles req_o,
// and waits for the resynchronized ack toggle. A one-entry skid buffer keeps upstream flowing.
module dd_hs_tx
    import dd_cdc_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

    hs_tx_state_t          r_state;
    logic                  r_req;
    logic                  r_done;
    logic                  r_pend_v;
    logic [WIDTH-1:0]      r_pend;
    logic [WIDTH-1:0]      r_data;
    logic [XFER_CNT_W-1:0] r_cnt;
    logic                  w_ack_s;
    logic                  w_accept;

    dd_sync #(
        .WIDTH  (1),
        .STAGES (STAGES),
        .RST_VAL(1'b0)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (ack_i),
        .o_q  (w_ack_s)
    );

    assign w_accept = valid_i & ~r_pend_v;

    // The ack match is registered into r_done and acted on one edge later, so the
    // FSM only ever reacts to a flopped completion event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_done   <= 1'b0;
            r_pend_v <= 1'b0;
            r_pend   <= '0;
            r_data   <= RST_VAL;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= data_i;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_req   <= ~r_req;
                    r_state <= WAIT;
                    if (w_accept) begin
                        r_pend   <= data_i;
                        r_pend_v <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_done) begin
                        r_cnt <= r_cnt + XFER_CNT_W'(1);
                        if (r_pend_v) begin
                            r_data   <= r_pend;
                            r_pend_v <= 1'b0;
                            r_state  <= LOAD;
                        end else if (w_accept) begin
                            r_data  <= data_i;
                            r_state <= LOAD;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_done <= (w_ack_s == r_req);
                        if (w_accept) begin
                            r_pend   <= data_i;
                            r_pend_v <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o    = ~r_pend_v;
    assign data_o     = r_data;
    assign req_o      = r_req;
    assign busy_o     = (r_state != IDLE);
    assign xfer_cnt_o = r_cnt;

endmodule
